// File: rtl/f1_pkg.sv
// ---------------------------------------------------------------------------
// f1_pkg
// Shared types and constants for the F1 start-light random hold-time block.
//   delay_state_t : hold-time controller states
//   DEF_*         : default board timing (50 MHz sysclk, 250 ms minimum hold)
//   LFSR_TAP_*    : feedback taps, as offsets below the register width, so
//                   the taps are bit[W-1] and bit[W-2] (x^7+x^6+1 at W=7)
// ---------------------------------------------------------------------------
package f1_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } delay_state_t;

    localparam int DEF_CLK_PER_MS   = 50000;
    localparam int DEF_MIN_DELAY_MS = 250;
    localparam int DEF_LFSR_W       = 7;

    // Width of the latched delay and of the millisecond down-counter
    localparam int DELAY_W = 10;

    localparam int LFSR_TAP_A_OFFSET = 1;
    localparam int LFSR_TAP_B_OFFSET = 2;

endpackage

// File: rtl/f1_lfsr.sv
// ---------------------------------------------------------------------------
// f1_lfsr
// Fibonacci LFSR that shifts left, feeding bit[W-1] ^ bit[W-2] into bit 0.
// With a non-zero seed it walks all 2^W-1 non-zero states and never
// reaches zero.
// Ports:
//   sysclk : system clock, rising edge
//   rst    : asynchronous active-high reset, loads LFSR_SEED
//   en     : advance one step on each edge while high
//   q      : current register value
// ---------------------------------------------------------------------------
module f1_lfsr
    import f1_pkg::*;
#(
    parameter int                LFSR_W    = DEF_LFSR_W,
    parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_W'(1)
) (
    input  logic              sysclk,
    input  logic              rst,
    input  logic              en,
    output logic [LFSR_W-1:0] q
);

    logic feedback;

    assign feedback = q[LFSR_W - LFSR_TAP_A_OFFSET] ^ q[LFSR_W - LFSR_TAP_B_OFFSET];

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            q <= LFSR_SEED;
        end else if (en) begin
            q <= {q[LFSR_W-2:0], feedback};
        end
    end

endmodule

// File: rtl/f1_random_delay.sv
// ---------------------------------------------------------------------------
// f1_random_delay
// Random hold time between the tenth start light and "lights out".
// A rising edge on start_delay samples the free-running LFSR and starts a
// countdown of MIN_DELAY_MS + sample milliseconds; at expiry time_out is
// raised and held until the sequencer drops start_delay. Dropping
// start_delay before expiry aborts the countdown silently.
// Ports:
//   sysclk      : system clock, rising edge
//   rst         : asynchronous active-high reset
//   en_lfsr     : LFSR advances one step per edge while high
//   start_delay : level from sequencer; rise starts, low aborts/acknowledges
//   time_out    : high from delay expiry until start_delay falls
//   delay_ms    : delay latched at start, for display/debug
//   busy        : high while counting or holding time_out
// ---------------------------------------------------------------------------
module f1_random_delay
    import f1_pkg::*;
#(
    parameter int                CLK_PER_MS   = DEF_CLK_PER_MS,
    parameter int                LFSR_W       = DEF_LFSR_W,
    parameter int                MIN_DELAY_MS = DEF_MIN_DELAY_MS,
    parameter logic [LFSR_W-1:0] LFSR_SEED    = LFSR_W'(1)
) (
    input  logic               sysclk,
    input  logic               rst,
    input  logic               en_lfsr,
    input  logic               start_delay,
    output logic               time_out,
    output logic [DELAY_W-1:0] delay_ms,
    output logic               busy
);

    localparam int               PRE_W   = $clog2(CLK_PER_MS);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_PER_MS - 1);

    delay_state_t       state, state_d;
    logic [LFSR_W-1:0]  lfsr;
    logic [PRE_W-1:0]   prescaler, prescaler_d;
    logic [DELAY_W-1:0] ms_cnt, ms_cnt_d;
    logic [DELAY_W-1:0] delay_d;
    logic               time_out_d;
    logic               start_q;
    logic               rise;
    logic               ms_tick;

    f1_lfsr #(
        .LFSR_W    (LFSR_W),
        .LFSR_SEED (LFSR_SEED)
    ) u_lfsr (
        .sysclk (sysclk),
        .rst    (rst),
        .en     (en_lfsr),
        .q      (lfsr)
    );

    assign rise    = start_delay & ~start_q;
    assign ms_tick = (prescaler == PRE_MAX);
    assign busy    = (state == COUNT) || (state == DONE);

    // Next-state logic. Dropping start_delay outranks an expiry on the same
    // edge, so a late abort never produces a time_out pulse. The LFSR value
    // is sampled pre-edge and zero-extended before adding the minimum.
    always_comb begin
        state_d     = state;
        prescaler_d = prescaler;
        ms_cnt_d    = ms_cnt;
        delay_d     = delay_ms;
        time_out_d  = time_out;

        unique case (state)
            IDLE: begin
                time_out_d = 1'b0;
                if (rise) begin
                    delay_d     = DELAY_W'(MIN_DELAY_MS) + DELAY_W'(lfsr);
                    ms_cnt_d    = DELAY_W'(MIN_DELAY_MS) + DELAY_W'(lfsr);
                    prescaler_d = '0;
                    state_d     = COUNT;
                end
            end
            COUNT: begin
                if (!start_delay) begin
                    state_d    = IDLE;
                    time_out_d = 1'b0;
                end else begin
                    prescaler_d = prescaler + PRE_W'(1);
                    if (ms_tick) begin
                        prescaler_d = '0;
                        ms_cnt_d    = ms_cnt - DELAY_W'(1);
                        if (ms_cnt == DELAY_W'(1)) begin
                            state_d    = DONE;
                            time_out_d = 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                time_out_d = 1'b1;
                if (!start_delay) begin
                    state_d    = IDLE;
                    time_out_d = 1'b0;
                end
            end
            default: begin
                state_d    = IDLE;
                time_out_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset clears everything including the
    // registered time_out, so it drops as soon as rst rises.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            prescaler <= '0;
            ms_cnt    <= '0;
            delay_ms  <= '0;
            time_out  <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            state     <= state_d;
            prescaler <= prescaler_d;
            ms_cnt    <= ms_cnt_d;
            delay_ms  <= delay_d;
            time_out  <= time_out_d;
            start_q   <= start_delay;
        end
    end

endmodule
